imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. Successor to the fixed 12-bit sign extender: it extracts the immediate for every RISC-V base format from a raw 32-bit instruction, sign- or zero-extends it to XLEN bits and optionally negates it. It has a valid/ready handshake on both sides and a saturating count of illegal-format requests. It sits between instruction fetch/decode and the ALU operand mux.

---
 rtl/imm_gen_pkg.sv | 25 ++
 rtl/imm_gen_pipe_extract.sv | 40 ++++
 rtl/imm_gen_pipe.sv | 112 +++++++++++
 tb/tb_imm_gen_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: format encodings,
// instruction width and the stage-1 payload.
package imm_gen_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_Z = 3'd5
  } fmt_e;

  // raw is already sign-extended to 32 bits for signed formats; the final
  // widening to XLEN happens in stage 2.
  typedef struct packed {
    logic [INSTR_W-1:0] raw;
    logic               zext;
    logic               neg;
    logic               illegal;
  } s1_payload_t;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: combinational field extraction for every RISC-V base
// immediate format plus the CSR zimm; codes 6-7 flag an illegal request.
module imm_extract
  import imm_gen_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         fmt,
  output logic [INSTR_W-1:0] raw,
  output logic               zext,
  output logic               illegal
);

  logic w_s;
  logic w_unused_opcode;

  assign w_s             = instr[31];
  assign w_unused_opcode = ^instr[6:0];

  always_comb begin
    raw     = '0;
    zext    = 1'b0;
    illegal = 1'b0;
    case (fmt)
      FMT_I: raw = {{20{w_s}}, instr[31:20]};
      FMT_S: raw = {{20{w_s}}, instr[31:25], instr[11:7]};
      FMT_B: raw = {{19{w_s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: raw = {instr[31:12], 12'b0};
      FMT_J: raw = {{11{w_s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z: begin
        raw  = {27'b0, instr[19:15]};
        zext = 1'b1;
      end
      default: begin
        illegal = 1'b1;
        zext    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage immediate generator with valid/ready on both sides
// and a saturating illegal-format counter. Optional negation: IMM_NEG_EN.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         fmt,
  input  logic               neg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    imm,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt
);

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_accept;
  logic [INSTR_W-1:0] w_raw;
  logic               w_zext;
  logic               w_illegal;
  logic [XLEN-1:0]    w_ext;
  logic [XLEN-1:0]    w_imm;

  s1_payload_t        r_s1;
  logic               r_s1_v;
  logic               r_s2_v;
  logic [XLEN-1:0]    r_imm;
  logic               r_err;
  logic [CNT_W-1:0]   r_err_cnt;

  imm_extract u_extract (
    .instr   (instr),
    .fmt     (fmt),
    .raw     (w_raw),
    .zext    (w_zext),
    .illegal (w_illegal)
  );

  // in_ready sees out_ready combinationally so a full pipe can still take a
  // new request on the edge where the consumer drains it.
  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1.raw     <= w_raw;
        r_s1.zext    <= w_zext;
        r_s1.neg     <= neg;
        r_s1.illegal <= w_illegal;
      end
    end
  end

  always_comb begin
    w_ext = '0;
    if (!r_s1.illegal) begin
      if (r_s1.zext) w_ext = XLEN'(r_s1.raw);
      else           w_ext = XLEN'($signed(r_s1.raw));
    end
  end

`ifdef IMM_NEG_EN
  assign w_imm = (r_s1.neg && !r_s1.illegal) ? (~w_ext + XLEN'(1)) : w_ext;
`else
  logic w_unused_neg;
  assign w_unused_neg = r_s1.neg;
  assign w_imm        = w_ext;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_imm  <= '0;
      r_err  <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_imm <= w_imm;
        r_err <= r_s1.illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && w_illegal && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_v;
  assign imm       = r_imm;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised bench for imm_gen_pipe (XLEN=64) against a format-level
// reference model and an in-order scoreboard.
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 8;

  typedef struct {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [2:0]       fmt = '0;
  logic             neg = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  imm;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  int   cnt_model = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .fmt       (fmt),
    .neg       (neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm       (imm),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Immediate value from the format rules, as plain signed arithmetic.
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] f, input logic ng);
    exp_t             r;
    longint           v;
    logic signed [11:0] f12;
    logic signed [12:0] f13;
    logic signed [20:0] f21;
    logic signed [31:0] f32;
    r.err = 1'b0;
    v = 0;
    case (f)
      3'd0: begin f12 = ins[31:20]; v = f12; end
      3'd1: begin f12 = {ins[31:25], ins[11:7]}; v = f12; end
      3'd2: begin f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = f13; end
      3'd3: begin f32 = {ins[31:12], 12'b0}; v = f32; end
      3'd4: begin f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = f21; end
      3'd5: v = {59'b0, ins[19:15]};
      default: r.err = 1'b1;
    endcase
`ifdef IMM_NEG_EN
    if (ng && !r.err) v = -v;
`else
    if (ng) v = v;
`endif
    r.imm = v;
    return r;
  endfunction

  // One handshake cycle: call at a falling edge, returns at the next one.
  task automatic step(input logic v, input logic [31:0] ins, input logic [2:0] f,
                      input logic ng, input logic ordy);
    logic fi, fo;
    exp_t e;
    in_valid = v; instr = ins; fmt = f; neg = ng; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
    fo = out_valid && ordy;
    fi = v && in_ready;
    if (fo) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("imm", imm, q[0].imm);
        chk("err", err, q[0].err);
      end
    end
    @(posedge clk);
    if (fo && q.size() > 0) void'(q.pop_front());
    if (fi) begin
      e = model(ins, f, ng);
      q.push_back(e);
      if (e.err && cnt_model < 255) cnt_model++;
    end
    @(negedge clk);
    chk("err_cnt", err_cnt, cnt_model);
  endtask

  // Single request with out_ready high: result must show exactly 2 edges later.
  task automatic send_one(input string tag, input logic [31:0] ins, input logic [2:0] f,
                          input logic ng, input logic [63:0] exp);
    in_valid = 1'b1; instr = ins; fmt = f; neg = ng; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_early"}, out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    #1 chk({tag, "_valid"}, out_valid, 1);
    chk(tag, imm, exp);
    chk({tag, "_err"}, err, 0);
    @(negedge clk);
  endtask

  logic [11:0] itab [6] = '{12'h005, 12'h00C, 12'hFFB, 12'hFF4, 12'h539, 12'h81D};
  logic [63:0] otab [6] = '{64'h5, 64'hC, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFF4,
                            64'h539, 64'hFFFFFFFFFFFFF81D};
  logic [63:0] ones_tab [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                                64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFF000,
                                64'hFFFFFFFFFFFFFFFE, 64'h1F};

  initial begin
    logic [63:0] plain;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", imm, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      send_one("i_fmt", {itab[i], 20'h00013}, 3'd0, 1'b0, otab[i]);
    for (int f = 0; f < 6; f++)
      send_one("ones", 32'hFFFFFFFF, 3'(f), 1'b0, ones_tab[f]);

    send_one("plain1337", {12'd1337, 20'h00013}, 3'd0, 1'b0, 64'h539);
    plain = imm;
`ifdef IMM_NEG_EN
    send_one("neg1337", {12'd1337, 20'h00013}, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFAC7);
    chk("neg_sum", imm + plain, 0);
    send_one("neg_zero", 32'h00000013, 3'd0, 1'b1, 64'h0);
`else
    send_one("neg_ignored", {12'd1337, 20'h00013}, 3'd0, 1'b1, 64'h539);
    chk("neg_diff", imm - plain, 0);
`endif

    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom));
    for (int i = 0; i < 300; i++)
      step(1'b1, $urandom, 3'd6, 1'($urandom), 1'b1);
    chk("err_cnt_sat", err_cnt, 255);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    chk("drained", q.size(), 0);

    // Fill both stages, then reset between edges.
    in_valid = 1'b1; fmt = 3'd6; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("full_in_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    q.delete();
    cnt_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ghost", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
